// File: rtl/prbs_seq_ctrl.sv
// Sequencer for an external 32-bit PRBS shift register: serially seeds it,
// discards a warm-up run, then collects its output into handshaked 32-bit words.
module prbs_seq_ctrl #(
    parameter int unsigned WARMUP = 32,
    parameter int unsigned N_MAX  = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [31:0]  seed,
    input  logic [7:0]   n_words,
    input  logic         prbs_out,
    input  logic         word_ready,
    output logic         prbs_sel,
    output logic [255:0] prbs_data,
    output logic [31:0]  word,
    output logic         word_valid,
    output logic         busy,
    output logic         done,
    output logic         err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WARMUP,
        S_RUN,
        S_VALID,
        S_DONE
    } state_t;

    localparam logic [7:0] WARM_LAST = 8'((WARMUP == 0) ? 0 : WARMUP - 1);

    state_t      state_q, state_d;
    logic [31:0] seed_q, seed_d;
    logic [7:0]  n_words_q, n_words_d;
    logic [7:0]  word_cnt_q, word_cnt_d;
    logic [4:0]  load_cnt_q, load_cnt_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  warm_cnt_q, warm_cnt_d;
    logic [31:0] collect_q, collect_d;
    logic [31:0] word_q, word_d;
    logic        word_valid_q, word_valid_d;
    logic        err_q, err_d;
    logic        start_ok;

    assign start_ok = (seed != '0) && (n_words != '0) && (32'(n_words) <= N_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            seed_q       <= '0;
            n_words_q    <= '0;
            word_cnt_q   <= '0;
            load_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            warm_cnt_q   <= '0;
            collect_q    <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            seed_q       <= seed_d;
            n_words_q    <= n_words_d;
            word_cnt_q   <= word_cnt_d;
            load_cnt_q   <= load_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            warm_cnt_q   <= warm_cnt_d;
            collect_q    <= collect_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        seed_d       = seed_q;
        n_words_d    = n_words_q;
        word_cnt_d   = word_cnt_q;
        load_cnt_d   = load_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        warm_cnt_d   = warm_cnt_q;
        collect_d    = collect_q;
        word_d       = word_q;
        word_valid_d = word_valid_q;
        err_d        = 1'b0;

        if (abort) begin
            state_d      = S_IDLE;
            word_valid_d = 1'b0;
            word_cnt_d   = '0;
            load_cnt_d   = '0;
            bit_cnt_d    = '0;
            warm_cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (!start_ok) begin
                            err_d = 1'b1;
                        end else begin
                            seed_d     = seed;
                            n_words_d  = n_words;
                            word_cnt_d = '0;
                            load_cnt_d = '0;
                            state_d    = S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    load_cnt_d = load_cnt_q + 5'd1;
                    if (load_cnt_q == 5'd31) begin
                        warm_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = (WARMUP == 0) ? S_RUN : S_WARMUP;
                    end
                end
                S_WARMUP: begin
                    if (warm_cnt_q == WARM_LAST) begin
                        warm_cnt_d = '0;
                        state_d    = S_RUN;
                    end else begin
                        warm_cnt_d = warm_cnt_q + 8'd1;
                    end
                end
                S_RUN: begin
                    collect_d[bit_cnt_q] = prbs_out;
                    bit_cnt_d            = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd31) begin
                        // last bit bypasses collect_q so the word is complete this edge
                        word_d       = {prbs_out, collect_q[30:0]};
                        word_valid_d = 1'b1;
                        state_d      = S_VALID;
                    end
                end
                S_VALID: begin
                    if (word_ready) begin
                        word_valid_d = 1'b0;
                        word_cnt_d   = word_cnt_q + 8'd1;
                        bit_cnt_d    = '0;
                        state_d      = ((word_cnt_q + 8'd1) == n_words_q) ? S_DONE : S_RUN;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        prbs_sel  = (state_q != S_LOAD);
        prbs_data = '0;
        if (state_q == S_LOAD) begin
            prbs_data[0] = seed_q[load_cnt_q];
        end
        busy       = (state_q != S_IDLE);
        done       = (state_q == S_DONE);
        word       = word_q;
        word_valid = word_valid_q;
        err        = err_q;
    end

endmodule
